regfile_port_ctrl: RTL and testbench
====================================

Name: regfile_port_ctrl

Overview:
Controller for the 16x16 register file's single write port and two read ports. It clears every register after reset, then arbitrates the write port between pipeline writeback and a debug/test write requester. It also decodes source and destination addresses into the one-hot per-register read and write enables driving the register array. It sits between decode/writeback and the register array.

Parameters:
NUM_REGS, 16, number of registers; one-hot enable width.
ADDR_W, 4, register address width (log2 NUM_REGS).
DATA_W, 16, register data width.
STARVE_LIM, 4, consecutive denied debug cycles before debug is forced through.
ZERO_REG, 1, when 1, register 0 is write-protected (reads as reset value 0).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
wb_req  in  1  writeback wants to write this cycle.
wb_addr  in  ADDR_W  writeback destination.
wb_data  in  DATA_W  writeback data.
dbg_req  in  1  debug write request; held until granted.
dbg_addr  in  ADDR_W  debug destination.
dbg_data  in  DATA_W  debug data.
dbg_grant  out  1  debug write performed at this clock edge (combinational).
src1_addr  in  ADDR_W  read port 1 address.
src2_addr  in  ADDR_W  read port 2 address.
rd_en1  out  NUM_REGS  one-hot read enable, port 1.
rd_en2  out  NUM_REGS  one-hot read enable, port 2.
wr_en  out  NUM_REGS  one-hot write enable (at most one bit set).
wr_data  out  DATA_W  data to all cells' D inputs.
init_busy  out  1  clear sweep in progress.
stall  out  1  pipeline must hold; a writeback offered this cycle is not performed.

Behaviour:
- States: INIT and RUN. The state register, a sweep counter (ADDR_W bits) and a starvation counter (ceil(log2(STARVE_LIM+1)) bits) are the only state. All outputs are combinational from state and inputs.
- Reset (rst=1 at an edge): state=INIT, sweep=0, starve=0. Values in the following cycle: init_busy=1, stall=1, wr_en=0x0001, wr_data=0, rd_en1=rd_en2=0, dbg_grant=0.
- INIT: wr_en=one-hot(sweep), wr_data=0, rd_en*=0, stall=1, wb_req and dbg_req ignored. sweep increments each cycle. Register NUM_REGS-1 is written in the cycle where sweep=NUM_REGS-1, and the next state is RUN. Sweep lasts exactly NUM_REGS cycles. Register 0 is written even when ZERO_REG=1.
- Reset mid-sweep or in RUN: immediate return to INIT, sweep restarts at 0, starve cleared.
- RUN read: rd_en1=one-hot(src1_addr) and rd_en2=one-hot(src2_addr), always, including when both addresses are equal. Same-cycle write-to-read forwarding is provided by the cells; this block does nothing for it.
- RUN arbitration, normal (starve<STARVE_LIM): wb_req has priority.
  - wb_req=1: writeback wins. If dbg_req=1, starve increments.
  - wb_req=0, dbg_req=1: dbg_grant=1, debug writes, starve cleared.
  - No request: wr_en=0, starve unchanged.
- RUN arbitration, forced (starve==STARVE_LIM and dbg_req=1): dbg_grant=1 and stall=1. The writeback is not performed and the pipeline re-presents it next cycle. starve cleared.
- stall=0 in RUN except in the forced case.
- dbg_req dropped before grant: starve cleared.
- Winner sets wr_en=one-hot(addr) and wr_data=its data.
- ZERO_REG=1 and winner addr=0: wr_en=0, but the request counts as served (dbg_grant still 1, starve cleared). wr_data still shows the winner's data.
- wr_en is never multi-hot. No output is X after the first reset edge.

Test Plan:
- Reset sweep: rst high 1 cycle, then low -> wr_en walks 0x0001..0x8000 over 16 cycles, wr_data=0, init_busy=1, stall=1. Cycle 17: init_busy=0, stall=0.
- Writeback: RUN, wb_req=1, wb_addr=5, wb_data=0xBEEF, src1_addr=5 -> wr_en=0x0020, wr_data=0xBEEF, rd_en1=0x0020, dbg_grant=0.
- Contention: wb_req and dbg_req both high for 4 cycles (dbg_addr=3, dbg_data=0x1234) -> writeback wins cycles 1-4. Cycle 5: dbg_grant=1, wr_en=0x0008, stall=1, starve back to 0.
- Idle debug: wb_req=0, dbg_req=1, dbg_addr=9, dbg_data=0x00A5 -> dbg_grant=1 same cycle, wr_en=0x0200, wr_data=0x00A5.
- Zero register: wb_req=1, wb_addr=0, data=0xFFFF -> wr_en=0. Register 0 still reads 0.
- Reset mid-operation: assert rst at sweep=7, and again during RUN with dbg pending starve=3 -> sweep restarts at 0x0001 for a full 16 cycles, starve=0, dbg_grant=0 throughout INIT.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_port_ctrl
//  Purpose  : Clear sweep after reset, write-port arbitration (writeback vs.
//             debug with anti-starvation) and one-hot read/write decode.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_port_ctrl #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_req,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                dbg_req,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_data,
  output logic                dbg_grant,
  input  logic [ADDR_W-1:0]   src1_addr,
  input  logic [ADDR_W-1:0]   src2_addr,
  output logic [NUM_REGS-1:0] rd_en1,
  output logic [NUM_REGS-1:0] rd_en2,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic                init_busy,
  output logic                stall
);

  localparam int STARVE_W = $clog2(STARVE_LIM + 1);

  localparam logic [0:0] c_ST_INIT = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [0:0]          r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_sweep, w_sweep_nxt;
  logic [STARVE_W-1:0] r_starve, w_starve_nxt;

  logic                w_run, w_starved, w_forced, w_dbg_win, w_wb_win;
  logic                w_protect;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [NUM_REGS-1:0] w_oh_sweep, w_oh_src1, w_oh_src2, w_oh_win;

  assign w_run      = (r_state == c_ST_RUN);
  assign w_starved  = (r_starve == STARVE_W'(STARVE_LIM));
  // Debug is forced through once starved, regardless of writeback.
  assign w_forced   = w_run && dbg_req && w_starved;
  assign w_dbg_win  = w_run && dbg_req && (!wb_req || w_starved);
  assign w_wb_win   = w_run && wb_req && !w_dbg_win;
  assign w_win_addr = w_dbg_win ? dbg_addr : wb_addr;
  assign w_protect  = (ZERO_REG != 0) && (w_win_addr == '0);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    assign w_oh_sweep[gi] = (r_sweep    == ADDR_W'(gi));
    assign w_oh_src1[gi]  = (src1_addr  == ADDR_W'(gi));
    assign w_oh_src2[gi]  = (src2_addr  == ADDR_W'(gi));
    assign w_oh_win[gi]   = (w_win_addr == ADDR_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_ST_INIT;
      r_sweep  <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sweep  <= w_sweep_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sweep_nxt  = r_sweep;
    w_starve_nxt = r_starve;
    case (r_state)
      c_ST_RUN: begin
        // Starve only grows while debug is waiting behind writeback.
        if (dbg_req && wb_req && !w_starved)
          w_starve_nxt = r_starve + STARVE_W'(1);
        else
          w_starve_nxt = '0;
      end
      default: begin
        w_starve_nxt = '0;
        if (r_sweep == ADDR_W'(NUM_REGS - 1)) begin
          w_sweep_nxt = '0;
          w_state_nxt = c_ST_RUN;
        end else begin
          w_sweep_nxt = r_sweep + ADDR_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    rd_en1    = '0;
    rd_en2    = '0;
    wr_en     = '0;
    wr_data   = '0;
    dbg_grant = 1'b0;
    stall     = 1'b0;
    init_busy = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        rd_en1 = w_oh_src1;
        rd_en2 = w_oh_src2;
        stall  = w_forced;
        if (w_dbg_win) begin
          dbg_grant = 1'b1;
          wr_data   = dbg_data;
          wr_en     = w_protect ? '0 : w_oh_win;
        end else if (w_wb_win) begin
          wr_data   = wb_data;
          wr_en     = w_protect ? '0 : w_oh_win;
        end
      end
      default: begin
        wr_en     = w_oh_sweep;
        stall     = 1'b1;
        init_busy = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_port_ctrl
//  Purpose  : Directed stimulus with a queue-based scoreboard for regfile_port_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_req, dbg_req;
  logic [3:0]  wb_addr, dbg_addr, src1_addr, src2_addr;
  logic [15:0] wb_data, dbg_data;
  logic        dbg_grant, init_busy, stall;
  logic [15:0] rd_en1, rd_en2, wr_en, wr_data;

  regfile_port_ctrl dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_grant(dbg_grant),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .rd_en1(rd_en1), .rd_en2(rd_en2),
    .wr_en(wr_en), .wr_data(wr_data),
    .init_busy(init_busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] wr_en;
    logic [15:0] wr_data;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        grant;
    logic        stall;
    logic        busy;
    logic        chk_data;
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    n_total = 0;
  int    n_pass  = 0;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got 0x%04h, want 0x%04h", nm, fld, act, exp);
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued entry is checked.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t  e;
      string nm;
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      chk(nm, "wr_en",     wr_en,            e.wr_en);
      if (e.chk_data) chk(nm, "wr_data", wr_data, e.wr_data);
      chk(nm, "rd_en1",    rd_en1,           e.rd1);
      chk(nm, "rd_en2",    rd_en2,           e.rd2);
      chk(nm, "dbg_grant", 16'(dbg_grant),   16'(e.grant));
      chk(nm, "stall",     16'(stall),       16'(e.stall));
      chk(nm, "init_busy", 16'(init_busy),   16'(e.busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [3:0] wa, input logic [15:0] wd,
                       input logic dr, input logic [3:0] da, input logic [15:0] dd,
                       input logic [3:0] s1, input logic [3:0] s2);
    wb_req = wr; wb_addr = wa; wb_data = wd;
    dbg_req = dr; dbg_addr = da; dbg_data = dd;
    src1_addr = s1; src2_addr = s2;
  endtask

  task automatic push(input string nm, input logic [15:0] we, input logic [15:0] wd,
                      input logic [15:0] r1, input logic [15:0] r2,
                      input logic g, input logic s, input logic b, input logic cd);
    exp_t e;
    e = '{wr_en: we, wr_data: wd, rd1: r1, rd2: r2, grant: g, stall: s, busy: b, chk_data: cd};
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  // Expect n sweep cycles starting at sweep=0; requests held high must be ignored.
  task automatic sweep(input string nm, input int n);
    for (int k = 0; k < n; k++) begin
      push(nm, 16'(1) << k, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 4'd4, 16'h4444, 1'b1, 4'd3, 16'h1234, 4'd1, 4'd2);
    tick();
    rst = 1'b0;
    sweep("init_sweep", 16);

    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd2, 4'd2);
    push("run_idle", 16'h0000, 16'h0, 16'h0004, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    drive(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0, 4'd5, 4'd0);
    push("writeback", 16'h0020, 16'hBEEF, 16'h0020, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h00A5, 4'd9, 4'd15);
    push("idle_debug", 16'h0200, 16'h00A5, 16'h0200, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();

    drive(1'b1, 4'd7, 16'h7777, 1'b1, 4'd3, 16'h1234, 4'd1, 4'd1);
    for (int c = 0; c < 4; c++) begin
      push("contend_wb", 16'h0080, 16'h7777, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    push("contend_forced", 16'h0008, 16'h1234, 16'h0002, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    push("after_forced", 16'h0080, 16'h7777, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // starve=1 here; dropping dbg_req must clear it so a fresh wait takes 4 cycles.
    drive(1'b1, 4'd7, 16'h7777, 1'b0, 4'd3, 16'h1234, 4'd1, 4'd1);
    push("dbg_dropped", 16'h0080, 16'h7777, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'd6, 16'h6666, 1'b1, 4'd10, 16'h0A0A, 4'd1, 4'd1);
    for (int c = 0; c < 4; c++) begin
      push("rewait_wb", 16'h0040, 16'h6666, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    push("rewait_forced", 16'h0400, 16'h0A0A, 16'h0002, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();

    drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    push("zero_wb", 16'h0000, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h5555, 4'd0, 4'd3);
    push("zero_dbg", 16'h0000, 16'h5555, 16'h0001, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 4'd4, 16'h4444, 1'b1, 4'd3, 16'h1234, 4'd1, 4'd2);
    sweep("sweep_pre", 7);
    push("sweep_at7", 16'h0080, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep("sweep_restart", 16);

    // Build starve=3, then reset while debug is still pending.
    drive(1'b1, 4'd7, 16'h7777, 1'b1, 4'd3, 16'h1234, 4'd1, 4'd1);
    for (int c = 0; c < 3; c++) begin
      push("pre_rst_wb", 16'h0080, 16'h7777, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep("sweep_run_rst", 16);
    for (int c = 0; c < 4; c++) begin
      push("post_rst_wb", 16'h0080, 16'h7777, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    push("post_rst_forced", 16'h0008, 16'h1234, 16'h0002, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();

    @(negedge clk);
    #1;
    n_total++;
    if (q_exp.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left, want 0", q_exp.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
